// File: rtl/wbm_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wbm_rd_pkg
//  Description : Shared constants and types for the Wishbone burst reader.
//                Holds the Wishbone cycle-type and burst-type encodings, the
//                byte-select constant and the reader state enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package wbm_rd_pkg;

    // Wishbone registered-feedback cycle type encodings
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Linear burst, all eight byte lanes enabled
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [7:0] SEL_ALL     = 8'hFF;

    // Reader control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

endpackage : wbm_rd_pkg
`default_nettype wire

// File: rtl/wbm_rd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wbm_rd_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head word is
//                visible on data_o whenever valid_o is high; data_o reads as
//                zero while empty. Push while full and pop while empty are
//                ignored. count_o reports the current occupancy.
//  Ports       : clk_i, rst_i   clock, synchronous active-high reset
//                push_i, data_i write request and data
//                pop_i          consume head word
//                data_o, valid_o head word and not-empty flag
//                count_o        number of stored words (0..DEPTH)
//  Parameters  : WIDTH word width, DEPTH entries (power of 2, >= 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module wbm_rd_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_FULL);
    assign w_push  = push_i & ~w_full;
    assign w_pop   = pop_i & ~w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = w_empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o = ~w_empty;
    assign count_o = count_q;

endmodule : wbm_rd_fifo
`default_nettype wire

// File: rtl/wbm_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : wbm_burst_reader
//  Description : Wishbone read initiator. Accepts a (byte address, word count)
//                command and fetches that many 64-bit words with incrementing
//                bursts of at most MAX_BURST beats. A burst is only started
//                once the output FIFO has room for every beat of it, so
//                received data is never dropped. Words leave through a
//                valid/ready stream fed from a first-word-fall-through FIFO.
//  Ports       : wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//                cmd_valid_i/cmd_ready_o   command handshake (ready in IDLE)
//                cmd_addr_i, cmd_len_i     start byte address, length in words
//                wb_*                      Wishbone master port (64-bit)
//                dat_o/dat_valid_o/dat_ready_i  output word stream
//                busy_o                    command in progress
//                done_o, err_o             completion / abort pulses
//  Option      : WBM_RD_TIMEOUT_EN - when defined, a BURST that sees no
//                termination for TIMEOUT cycles is aborted like an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module wbm_burst_reader
    import wbm_rd_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    // command
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    // Wishbone master
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [7:0]        wb_sel_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    input  logic [63:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i,
    // output stream
    output logic [63:0]       dat_o,
    output logic              dat_valid_o,
    input  logic              dat_ready_i,
    // status
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] adr_q,   adr_d;
    logic [LEN_W-1:0]  rem_q,   rem_d;
    logic [BW-1:0]     beats_q, beats_d;
    logic              cyc_q,   cyc_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;

    logic [CW-1:0]     w_fifo_count;
    logic [CW-1:0]     w_free;
    logic [BW-1:0]     w_blen;
    logic              w_room;
    logic              w_start;
    logic              w_err_t;
    logic              w_rty_t;
    logic              w_ack_t;
    logic              w_timeout;
    logic              w_abort;

    // Low address bits are forced to zero; the incoming ones are unused.
    logic              w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^cmd_addr_i[2:0];

    // ------------------------------------------------------------------
    // Burst sizing and FIFO room check
    // ------------------------------------------------------------------
    always_comb begin
        if (32'(rem_q) < 32'(MAX_BURST)) begin
            w_blen = BW'(rem_q);
        end else begin
            w_blen = BW'(MAX_BURST);
        end
    end

    // Room must cover the whole burst; pops while it runs only add space.
    assign w_free  = CW'(FIFO_DEPTH) - w_fifo_count;
    assign w_room  = (w_free >= CW'(w_blen));
    assign w_start = (state_q == ST_REQ) && w_room;

    // Terminations only count while the cycle is open; err > rty > ack.
    assign w_err_t = cyc_q & wb_err_i;
    assign w_rty_t = cyc_q & ~wb_err_i & wb_rty_i;
    assign w_ack_t = cyc_q & ~wb_err_i & ~wb_rty_i & wb_ack_i;
    assign w_abort = w_err_t | w_timeout;

    // ------------------------------------------------------------------
    // Optional ack watchdog
    // ------------------------------------------------------------------
`ifdef WBM_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (w_start || w_ack_t || w_rty_t) begin
            tmo_d = '0;
        end else if (cyc_q && !w_err_t) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // Fires on the cycle whose closing edge would make the count TIMEOUT.
    assign w_timeout = cyc_q & ~wb_err_i & ~wb_rty_i & ~wb_ack_i &
                       (tmo_q == c_TMO_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        beats_d = beats_q;
        cyc_d   = cyc_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    adr_d = {cmd_addr_i[ADDR_W-1:3], 3'b000};
                    rem_d = cmd_len_i;
                    if (cmd_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (w_room) begin
                    cyc_d   = 1'b1;
                    beats_d = w_blen;
                    state_d = ST_BURST;
                end
            end

            ST_BURST: begin
                if (w_abort) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    rem_d   = '0;
                    state_d = ST_IDLE;
                end else if (w_rty_t) begin
                    // Address and remaining count are kept for the re-issue.
                    cyc_d   = 1'b0;
                    state_d = ST_GAP;
                end else if (w_ack_t) begin
                    adr_d   = adr_q + ADDR_W'(8);
                    beats_d = beats_q - BW'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    if (beats_q == BW'(1)) begin
                        cyc_d = 1'b0;
                        if (rem_q == LEN_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                end
            end

            ST_GAP: begin
                state_d = ST_REQ;
            end

            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            cyc_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    wbm_rd_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (w_ack_t),
        .data_i  (wb_dat_i),
        .pop_i   (dat_ready_i),
        .data_o  (dat_o),
        .valid_o (dat_valid_o),
        .count_o (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = 1'b0;
    assign wb_sel_o    = SEL_ALL;
    assign wb_bte_o    = BTE_LINEAR;
    assign wb_adr_o    = adr_q;
    assign wb_cti_o    = !cyc_q              ? CTI_CLASSIC :
                         (beats_q == BW'(1)) ? CTI_EOB     : CTI_INCR;

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule : wbm_burst_reader
`default_nettype wire

// File: tb/tb_wbm_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wbm_burst_reader
//  Description : Directed self-checking bench for wbm_burst_reader with a
//                zero-wait Wishbone responder that can inject a retry, an
//                error, or a missing ack on a chosen response. Responder
//                data for a beat is {~address, address}.
//                The watchdog scenario is built only with WBM_RD_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wbm_burst_reader;

    localparam int ADDR_W     = 32;
    localparam int LEN_W      = 16;
    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 32;
`ifdef WBM_RD_TIMEOUT_EN
    localparam int TB_TIMEOUT = 10;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    localparam logic [2:0] EXP_INCR = 3'b010;
    localparam logic [2:0] EXP_EOB  = 3'b111;

    logic              clk;
    logic              rst;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [LEN_W-1:0]  cmd_len_i;
    logic              wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]        wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic [1:0]        wb_bte_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [63:0]       wb_dat_i;
    logic              wb_ack_i, wb_err_i, wb_rty_i;
    logic [63:0]       dat_o;
    logic              dat_valid_o;
    logic              dat_ready_i;
    logic              busy_o, done_o, err_o;

    int checks = 0;
    int errors = 0;

    wbm_burst_reader #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .MAX_BURST  (MAX_BURST),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_len_i   (cmd_len_i),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_cti_o    (wb_cti_o),
        .wb_bte_o    (wb_bte_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .wb_rty_i    (wb_rty_i),
        .dat_o       (dat_o),
        .dat_valid_o (dat_valid_o),
        .dat_ready_i (dat_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Responder model: zero-wait; injection on response number inj_at
    // (1 = retry, 2 = error, 3 = no termination at all).
    // ------------------------------------------------------------------
    int cycle_n  = 0;
    int resp_n   = 0;
    int inj_at   = -1;
    int inj_kind = 0;

    function automatic logic [63:0] exp_word(input logic [31:0] a);
        return {~a, a};
    endfunction

    assign wb_dat_i = {~wb_adr_o, wb_adr_o};

    always_comb begin
        wb_ack_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_err_i = 1'b0;
        if (wb_cyc_o && wb_stb_o) begin
            if (resp_n == inj_at && inj_kind == 1)      wb_rty_i = 1'b1;
            else if (resp_n == inj_at && inj_kind == 2) wb_err_i = 1'b1;
            else if (resp_n == inj_at && inj_kind == 3) wb_ack_i = 1'b0;
            else                                        wb_ack_i = 1'b1;
        end
    end

    always @(posedge clk) begin
        cycle_n <= cycle_n + 1;
        if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_rty_i || wb_err_i))
            resp_n <= resp_n + 1;
    end

    // ------------------------------------------------------------------
    // Monitor (falling edge)
    // ------------------------------------------------------------------
    logic [31:0] mon_adr[$];
    logic [2:0]  mon_cti[$];
    int          mon_cyc[$];
    logic [63:0] out_q[$];
    int          out_cyc[$];
    int          done_cnt   = 0;
    int          done_at    = 0;
    bit          done_cyc_hi = 1'b0;
    int          err_cnt    = 0;
    int          cyc_hi_cnt = 0;

    always @(negedge clk) begin
        if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i) begin
            mon_adr.push_back(wb_adr_o);
            mon_cti.push_back(wb_cti_o);
            mon_cyc.push_back(cycle_n);
        end
        if (done_o) begin
            done_cnt++;
            done_at     = cycle_n;
            done_cyc_hi = wb_cyc_o;
        end
        if (err_o) err_cnt++;
        if (dat_valid_o && dat_ready_i) begin
            out_q.push_back(dat_o);
            out_cyc.push_back(cycle_n);
        end
        if (wb_cyc_o) cyc_hi_cnt++;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic issue_cmd(input logic [31:0] a, input logic [15:0] l);
        @(posedge clk); #1;
        cmd_valid_i = 1'b1;
        cmd_addr_i  = a;
        cmd_len_i   = l;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wb_cyc_o, wb_stb_o, done_o, err_o, busy_o, dat_valid_o, cmd_ready_o, wb_we_o} !== 8'b0000_0010) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000010", {wb_cyc_o, wb_stb_o, done_o, err_o, busy_o, dat_valid_o, cmd_ready_o, wb_we_o});
        end
        checks++;
        if ({wb_cti_o, wb_adr_o} !== 35'd0) begin
            errors++;
            $display("FAIL reset_bus: cti %b adr %h expected 000 / 0", wb_cti_o, wb_adr_o);
        end
        checks++;
        if (dat_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_dat: got %h expected 0", dat_o);
        end
        checks++;
        if ({wb_sel_o, wb_bte_o} !== 10'b1111_1111_00) begin
            errors++;
            $display("FAIL reset_sel_bte: got %h/%b expected ff/00", wb_sel_o, wb_bte_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int b  = mon_adr.size();
        int ob = out_q.size();
        int d0 = done_cnt;
        int nbad = 0;
        bit ok;
        dat_ready_i = 1'b1;
        issue_cmd(32'h100, 16'd5);
        @(negedge clk);
        checks++;
        if ({busy_o, wb_cyc_o, cmd_ready_o} !== 3'b100) begin
            errors++;
            $display("FAIL basic_req_cycle: busy/cyc/ready %b expected 100", {busy_o, wb_cyc_o, cmd_ready_o});
        end
        @(negedge clk);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_adr_o} !== {2'b11, 32'h100}) begin
            errors++;
            $display("FAIL basic_first_beat: cyc/stb %b adr %h expected 11 / 100", {wb_cyc_o, wb_stb_o}, wb_adr_o);
        end
        wait_idle(50, ok);
        settle();
        checks++;
        if (!ok || mon_adr.size() - b != 5) begin
            errors++;
            $display("FAIL basic_beats: idle %0d beats %0d expected 1 / 5", ok, mon_adr.size() - b);
        end
        for (int i = 0; i < 5; i++) begin
            if (b + i >= mon_adr.size()) nbad++;
            else if (mon_adr[b+i] !== 32'h100 + 32'(8*i) ||
                     mon_cti[b+i] !== ((i == 4) ? EXP_EOB : EXP_INCR)) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL basic_adr_cti: %0d bad beats expected 0", nbad);
        end
        checks++;
        if (done_cnt - d0 != 1 || mon_cyc.size() < b + 5 || done_at != mon_cyc[b+4] + 1 || done_cyc_hi !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: pulses %0d at %0d cyc_hi %0d expected 1 one cycle after last ack, cyc low", done_cnt - d0, done_at, done_cyc_hi);
        end
        nbad = 0;
        for (int i = 0; i < 5; i++) begin
            if (ob + i >= out_q.size()) nbad++;
            else if (out_q[ob+i] !== exp_word(32'h100 + 32'(8*i))) nbad++;
        end
        checks++;
        if (nbad != 0 || out_q.size() - ob != 5) begin
            errors++;
            $display("FAIL basic_data: %0d bad of %0d words expected 0 of 5", nbad, out_q.size() - ob);
        end
        checks++;
        if (out_cyc.size() <= ob || mon_cyc.size() <= b || out_cyc[ob] != mon_cyc[b] + 1) begin
            errors++;
            $display("FAIL basic_valid_latency: first word not visible the cycle after its ack");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base = 32'hFFFF_FFC0;
        int b  = mon_adr.size();
        int ob = out_q.size();
        int d0 = done_cnt;
        int nbad = 0;
        bit ok;
        dat_ready_i = 1'b1;
        issue_cmd(base, 16'd20);
        wait_idle(80, ok);
        settle();
        checks++;
        if (!ok || mon_adr.size() - b != 20 || out_q.size() - ob != 20 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL b2b_counts: idle %0d beats %0d words %0d done %0d expected 1/20/20/1", ok, mon_adr.size() - b, out_q.size() - ob, done_cnt - d0);
        end
        for (int i = 0; i < 20; i++) begin
            if (b + i >= mon_adr.size() || ob + i >= out_q.size()) nbad++;
            else if (mon_adr[b+i] !== base + 32'(8*i) ||
                     mon_cti[b+i] !== ((i == 15 || i == 19) ? EXP_EOB : EXP_INCR) ||
                     out_q[ob+i] !== exp_word(base + 32'(8*i))) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL b2b_wrap_data: %0d bad beats expected 0", nbad);
        end
        checks++;
        if (mon_cyc.size() < b + 17 || mon_cyc[b+16] - mon_cyc[b+15] != 3 || mon_cyc[b+1] - mon_cyc[b] != 1) begin
            errors++;
            $display("FAIL b2b_gap: burst spacing wrong, expected 1-cycle beats and 3-cycle burst turnaround");
        end
    endtask

    task automatic test_throttle();
        int b  = mon_adr.size();
        int ob = out_q.size();
        int d0 = done_cnt;
        int nbad = 0;
        dat_ready_i = 1'b0;
        issue_cmd(32'h2000, 16'd40);
        repeat (60) @(posedge clk); #1;
        checks++;
        if (mon_adr.size() - b != 32 || {busy_o, wb_cyc_o, dat_valid_o} !== 3'b101 || done_cnt != d0) begin
            errors++;
            $display("FAIL throttle_stall: beats %0d busy/cyc/valid %b expected 32 / 101", mon_adr.size() - b, {busy_o, wb_cyc_o, dat_valid_o});
        end
        dat_ready_i = 1'b1;
        repeat (7) @(posedge clk); #1;
        dat_ready_i = 1'b0;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (mon_adr.size() - b != 32) begin
            errors++;
            $display("FAIL throttle_7_free: beats %0d expected 32", mon_adr.size() - b);
        end
        dat_ready_i = 1'b1;
        @(posedge clk); #1;
        dat_ready_i = 1'b0;
        repeat (20) @(posedge clk); #1;
        checks++;
        if (mon_adr.size() - b != 40 || done_cnt - d0 != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL throttle_resume: beats %0d done %0d busy %b expected 40 / 1 / 0", mon_adr.size() - b, done_cnt - d0, busy_o);
        end
        dat_ready_i = 1'b1;
        repeat (40) @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            if (b + i >= mon_adr.size() || ob + i >= out_q.size()) nbad++;
            else if (mon_adr[b+i] !== 32'h2000 + 32'(8*i) ||
                     mon_cti[b+i] !== ((i == 15 || i == 31 || i == 39) ? EXP_EOB : EXP_INCR) ||
                     out_q[ob+i] !== exp_word(32'h2000 + 32'(8*i))) nbad++;
        end
        checks++;
        if (nbad != 0 || out_q.size() - ob != 40) begin
            errors++;
            $display("FAIL throttle_data: %0d bad of %0d words expected 0 of 40", nbad, out_q.size() - ob);
        end
    endtask

    task automatic test_retry();
        int b  = mon_adr.size();
        int ob = out_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int nbad = 0;
        bit ok;
        dat_ready_i = 1'b1;
        inj_at   = resp_n + 2;
        inj_kind = 1;
        issue_cmd(32'h300, 16'd4);
        wait_idle(60, ok);
        settle();
        inj_kind = 0;
        for (int i = 0; i < 4; i++) begin
            if (b + i >= mon_adr.size() || ob + i >= out_q.size()) nbad++;
            else if (mon_adr[b+i] !== 32'h300 + 32'(8*i) ||
                     mon_cti[b+i] !== ((i == 3) ? EXP_EOB : EXP_INCR) ||
                     out_q[ob+i] !== exp_word(32'h300 + 32'(8*i))) nbad++;
        end
        checks++;
        if (!ok || nbad != 0 || mon_adr.size() - b != 4 || out_q.size() - ob != 4) begin
            errors++;
            $display("FAIL retry_beats: idle %0d bad %0d beats %0d words %0d expected 1/0/4/4", ok, nbad, mon_adr.size() - b, out_q.size() - ob);
        end
        checks++;
        if (mon_cyc.size() < b + 3 || mon_cyc[b+2] - mon_cyc[b+1] != 4) begin
            errors++;
            $display("FAIL retry_gap: restart spacing wrong, expected 4 cycles from beat 2 to re-issued beat");
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            errors++;
            $display("FAIL retry_status: done %0d err %0d expected 1 / 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_error();
        int ob = out_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit ok = 1'b0;
        dat_ready_i = 1'b0;
        inj_at   = resp_n + 1;
        inj_kind = 2;
        issue_cmd(32'h400, 16'd6);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (err_o) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || {cmd_ready_o, wb_cyc_o, dat_valid_o} !== 3'b101 || dat_o !== exp_word(32'h400)) begin
            errors++;
            $display("FAIL error_abort: seen %0d ready/cyc/valid %b dat %h expected 1 / 101 / %h", ok, {cmd_ready_o, wb_cyc_o, dat_valid_o}, dat_o, exp_word(32'h400));
        end
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL error_pulse_width: err_o %b expected 0", err_o);
        end
        inj_kind = 0;
        @(posedge clk); #1;
        dat_ready_i = 1'b1;
        settle();
        checks++;
        if (out_q.size() - ob != 1 || dat_valid_o !== 1'b0 || done_cnt != d0 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL error_drain: words %0d valid %b done %0d err %0d expected 1/0/0/1", out_q.size() - ob, dat_valid_o, done_cnt - d0, err_cnt - e0);
        end
    endtask

`ifdef WBM_RD_TIMEOUT_EN
    task automatic test_timeout();
        int s = -1;
        int e = -1;
        dat_ready_i = 1'b1;
        inj_at   = resp_n;
        inj_kind = 3;
        issue_cmd(32'h800, 16'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wb_cyc_o) begin
                s = cycle_n;
                break;
            end
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (err_o) begin
                e = cycle_n;
                break;
            end
        end
        checks++;
        if (s < 0 || e < 0 || e - s != 10 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: stb at %0d err at %0d cyc %b expected err 10 cycles later with cyc low", s, e, wb_cyc_o);
        end
        inj_kind = 0;
        settle();
    endtask
`endif

    task automatic test_reset_mid();
        int ob;
        int d0;
        bit ok;
        dat_ready_i = 1'b0;
        issue_cmd(32'h500, 16'd16);
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_cyc_o, wb_stb_o, dat_valid_o, busy_o, cmd_ready_o} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_mid: cyc/stb/valid/busy/ready %b expected 00001", {wb_cyc_o, wb_stb_o, dat_valid_o, busy_o, cmd_ready_o});
        end
        ob = out_q.size();
        d0 = done_cnt;
        dat_ready_i = 1'b1;
        issue_cmd(32'h600, 16'd2);
        wait_idle(40, ok);
        settle();
        checks++;
        if (!ok || done_cnt - d0 != 1 || out_q.size() - ob != 2 ||
            out_q[ob] !== exp_word(32'h600) || out_q[ob+1] !== exp_word(32'h608)) begin
            errors++;
            $display("FAIL reset_mid_new_cmd: idle %0d done %0d words %0d expected 1/1/2 with data at 600,608", ok, done_cnt - d0, out_q.size() - ob);
        end
    endtask

    task automatic test_len0();
        int d0 = done_cnt;
        int c0 = cyc_hi_cnt;
        issue_cmd(32'h700, 16'd0);
        @(negedge clk);
        checks++;
        if ({done_o, cmd_ready_o, busy_o} !== 3'b110) begin
            errors++;
            $display("FAIL len0_done: done/ready/busy %b expected 110", {done_o, cmd_ready_o, busy_o});
        end
        settle();
        checks++;
        if (done_cnt - d0 != 1 || cyc_hi_cnt != c0) begin
            errors++;
            $display("FAIL len0_quiet: done pulses %0d cyc cycles %0d expected 1 / 0", done_cnt - d0, cyc_hi_cnt - c0);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequencer and watchdog
    // ------------------------------------------------------------------
    initial begin
        rst         = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_len_i   = '0;
        dat_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_throttle();
        test_retry();
        test_error();
`ifdef WBM_RD_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_len0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_wbm_burst_reader
`default_nettype wire
